sdspi_perf_meter: RTL

Cycle-accurate performance meter that sits directly downstream of the SD-SPI system under test. It times each transfer from the rising edge of `uut_start` to the rising edge of `uut_finish`, and keeps last/min/max statistics plus a run counter. A selected statistic is presented as a 32-bit word for the seven-segment display path.

---
 rtl/sdspi_perf_meter.sv | 138 +++++++++++++
 1 files changed

// File: rtl/sdspi_perf_meter.sv
`default_nettype none
// ============================================================================
// Module      : sdspi_perf_meter
// Description : Times uut_start-rise to uut_finish-rise; keeps last/min/max/run stats.
// Revision    : 1.0 - initial release
// ============================================================================
module sdspi_perf_meter #(
    parameter int          CNT_WIDTH      = 32,
    parameter int unsigned TIMEOUT_CYCLES = 100000000,
    parameter int          RUNS_WIDTH     = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  uut_start,
    input  logic                  uut_finish,
    input  logic [1:0]            sel,
    output logic                  busy,
    output logic                  result_valid,
    output logic                  timeout,
    output logic [CNT_WIDTH-1:0]  last_cycles,
    output logic [CNT_WIDTH-1:0]  min_cycles,
    output logic [CNT_WIDTH-1:0]  max_cycles,
    output logic [RUNS_WIDTH-1:0] run_count,
    output logic [31:0]           dout
);

    typedef enum logic [0:0] {
        S_IDLE    = 1'b0,
        S_MEASURE = 1'b1
    } state_t;

    localparam logic [CNT_WIDTH-1:0] C_TIMEOUT = CNT_WIDTH'(TIMEOUT_CYCLES);
    localparam logic [CNT_WIDTH-1:0] C_CNT_ONE = CNT_WIDTH'(1);
    localparam int C_WA = (CNT_WIDTH > 32) ? CNT_WIDTH : 32;
    localparam int C_W  = (RUNS_WIDTH > C_WA) ? RUNS_WIDTH : C_WA;

    state_t                  state_q;
    logic                    start_q;
    logic                    finish_q;
    logic                    valid_q;
    logic                    timeout_q;
    logic [CNT_WIDTH-1:0]    cnt_q;
    logic [CNT_WIDTH-1:0]    last_q;
    logic [CNT_WIDTH-1:0]    min_q;
    logic [CNT_WIDTH-1:0]    max_q;
    logic [RUNS_WIDTH-1:0]   runs_q;

    logic                    start_rise;
    logic                    finish_rise;
    logic [CNT_WIDTH-1:0]    cnt_d;
    logic [RUNS_WIDTH-1:0]   runs_d;
    logic [C_W-1:0]          sel_wide;

    assign start_rise  = uut_start & ~start_q;
    assign finish_rise = uut_finish & ~finish_q;
    assign cnt_d       = cnt_q + C_CNT_ONE;
    assign runs_d      = (&runs_q) ? runs_q : runs_q + RUNS_WIDTH'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            start_q   <= 1'b0;
            finish_q  <= 1'b0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            cnt_q     <= '0;
            last_q    <= '0;
            min_q     <= '1;
            max_q     <= '0;
            runs_q    <= '0;
        end else begin
            start_q  <= uut_start;
            finish_q <= uut_finish;
            valid_q  <= 1'b0;
            if (clear) begin
                state_q   <= S_IDLE;
                timeout_q <= 1'b0;
                cnt_q     <= '0;
                last_q    <= '0;
                min_q     <= '1;
                max_q     <= '0;
                runs_q    <= '0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start_rise) begin
                            state_q <= S_MEASURE;
                            cnt_q   <= C_CNT_ONE;
                        end
                    end
                    S_MEASURE: begin
                        // A finish landing on the timeout cycle still counts as a result.
                        if (finish_rise) begin
                            last_q  <= cnt_q;
                            runs_q  <= runs_d;
                            valid_q <= 1'b1;
                            state_q <= S_IDLE;
                            if (cnt_q < min_q) begin
                                min_q <= cnt_q;
                            end
                            if (cnt_q > max_q) begin
                                max_q <= cnt_q;
                            end
                        end else if (cnt_q == C_TIMEOUT) begin
                            timeout_q <= 1'b1;
                            state_q   <= S_IDLE;
                        end else begin
                            cnt_q <= cnt_d;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    always_comb begin
        sel_wide = '0;
        case (sel)
            2'd0:    sel_wide[CNT_WIDTH-1:0]  = last_q;
            2'd1:    sel_wide[CNT_WIDTH-1:0]  = min_q;
            2'd2:    sel_wide[CNT_WIDTH-1:0]  = max_q;
            default: sel_wide[RUNS_WIDTH-1:0] = runs_q;
        endcase
    end

    assign dout         = sel_wide[31:0];
    assign busy         = (state_q == S_MEASURE);
    assign result_valid = valid_q;
    assign timeout      = timeout_q;
    assign last_cycles  = last_q;
    assign min_cycles   = min_q;
    assign max_cycles   = max_q;
    assign run_count    = runs_q;

endmodule
`default_nettype wire
